// File: rtl/coms_frame_rx.sv
// coms_frame_rx: receive-side frame decoder for the iceboard motor bus.
// Hunts a 32-bit magic word, captures payload + CRC16 trailer, publishes good frames.
//
// state   | meaning
// HUNT    | sliding match of incoming bytes against MAGIC_NUMBER
// RECEIVE | capture payload and CRC trailer, inter-byte gap timer running
// CHECK   | single cycle: compare CRC, apply id filter, publish result
module coms_frame_rx #(
    parameter logic [31:0] MAGIC_NUMBER  = 32'h1CEB00DA,
    parameter int          PAYLOAD_BYTES = 24,
    parameter int          CLK_FREQ_HZ   = 50_000_000,
    parameter int          BAUDRATE      = 115200,
    parameter int          TIMEOUT_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_data_ready,
    input  logic [7:0]                   rx_data,
    input  logic                         id_filter_en,
    input  logic [7:0]                   expected_id,
    output logic                         frame_valid,
    output logic [7:0]                   frame_id,
    output logic [8*PAYLOAD_BYTES-1:0]   frame_payload,
    output logic                         crc_error,
    output logic                         id_mismatch,
    output logic                         timeout,
    output logic                         busy,
    output logic [15:0]                  crc_error_count,
    output logic [31:0]                  frame_count
);

    localparam int PAY_W          = 8 * PAYLOAD_BYTES;
    localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / BAUDRATE * 10 * TIMEOUT_BYTES;
    localparam int TMR_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W          = $clog2(PAYLOAD_BYTES + 2);

    localparam logic [CNT_W-1:0] CRC_HI_IDX = CNT_W'(PAYLOAD_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(PAYLOAD_BYTES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        RECEIVE = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [31:0]        magic_sr;
    logic [31:0]        magic_shift;
    logic               magic_hit;
    logic               gap_expired;
    logic [15:0]        crc;
    logic [15:0]        rx_crc;
    logic [CNT_W-1:0]   byte_cnt;
    logic [TMR_W-1:0]   gap_timer;
    logic [PAY_W-1:0]   payload_buf;
    logic               crc_ok;
    logic               id_ok;

    // x^16+x^15+x^2+1, data MSB first, no reflection
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign magic_shift = {magic_sr[23:0], rx_data};
    assign crc_ok      = (crc == rx_crc);
    assign id_ok       = !id_filter_en || (payload_buf[PAY_W-1 -: 8] == expected_id);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= HUNT;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        magic_hit   = 1'b0;
        gap_expired = 1'b0;
        busy        = (state != HUNT);
        case (state)
            HUNT: begin
                if (rx_data_ready && (magic_shift == MAGIC_NUMBER)) begin
                    magic_hit  = 1'b1;
                    state_next = RECEIVE;
                end
            end
            RECEIVE: begin
                if (rx_data_ready) begin
                    if (byte_cnt == LAST_IDX) state_next = CHECK;
                end else if (gap_timer == TMR_LAST) begin
                    gap_expired = 1'b1;
                    state_next  = HUNT;
                end
            end
            CHECK:   state_next = HUNT;
            default: state_next = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            magic_sr        <= 32'h0;
            crc             <= 16'hFFFF;
            rx_crc          <= 16'h0;
            byte_cnt        <= '0;
            gap_timer       <= '0;
            payload_buf     <= '0;
            frame_valid     <= 1'b0;
            frame_id        <= 8'h0;
            frame_payload   <= '0;
            crc_error       <= 1'b0;
            id_mismatch     <= 1'b0;
            timeout         <= 1'b0;
            crc_error_count <= 16'h0;
            frame_count     <= 32'h0;
        end else begin
            frame_valid <= 1'b0;
            crc_error   <= 1'b0;
            id_mismatch <= 1'b0;
            timeout     <= gap_expired;
            case (state)
                HUNT: begin
                    if (rx_data_ready) magic_sr <= magic_shift;
                    if (magic_hit) begin
                        crc       <= 16'hFFFF;
                        byte_cnt  <= '0;
                        gap_timer <= '0;
                    end
                end
                RECEIVE: begin
                    if (rx_data_ready) begin
                        gap_timer <= '0;
                        byte_cnt  <= byte_cnt + 1'b1;
                        // payload shifts in from the LSB end so byte 0 lands in the MSBs
                        if (byte_cnt < CRC_HI_IDX) begin
                            crc         <= crc16_byte(crc, rx_data);
                            payload_buf <= {payload_buf[PAY_W-9:0], rx_data};
                        end else if (byte_cnt == CRC_HI_IDX) begin
                            rx_crc[15:8] <= rx_data;
                        end else begin
                            rx_crc[7:0]  <= rx_data;
                        end
                    end else begin
                        gap_timer <= gap_timer + 1'b1;
                    end
                end
                CHECK: begin
                    // payload bytes must not complete a stale magic match
                    magic_sr <= rx_data_ready ? {24'h0, rx_data} : 32'h0;
                    if (!crc_ok) begin
                        crc_error <= 1'b1;
                        if (crc_error_count != 16'hFFFF) crc_error_count <= crc_error_count + 1'b1;
                    end else if (id_ok) begin
                        frame_valid   <= 1'b1;
                        frame_id      <= payload_buf[PAY_W-1 -: 8];
                        frame_payload <= payload_buf;
                        frame_count   <= frame_count + 1'b1;
                    end else begin
                        id_mismatch <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
